// File: rtl/traffic_light_controller_nway.sv
// N-way round-robin intersection controller.
// Each approach gets green, then yellow, then an all-red clearance. Approaches
// with no waiting vehicle are skipped. A green phase is extended while no other
// approach has demand. Night mode replaces normal operation with flashing yellow.
// All lamp outputs, active_way and phase_cnt come straight from registers.
module traffic_light_controller_nway #(
  parameter int NUM_WAYS      = 4,
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int FLASH_CYCLES  = 5,
  parameter int CNT_W         = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WAYS-1:0]         car_sense,
  input  logic                        night_mode,
  output logic [NUM_WAYS-1:0]         green,
  output logic [NUM_WAYS-1:0]         yellow,
  output logic [NUM_WAYS-1:0]         red,
  output logic [$clog2(NUM_WAYS)-1:0] active_way,
  output logic [CNT_W-1:0]            phase_cnt
);

  localparam int WW = $clog2(NUM_WAYS);

  // Last counter value of each fixed-length phase (phase_cnt is 0-based).
  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] F_LAST  = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [WW-1:0]    LAST_WAY = WW'(NUM_WAYS - 1);

  typedef enum logic [1:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALL_RED,
    ST_FLASH
  } state_t;

  state_t                state_q, state_d;
  logic [WW-1:0]         way_q, way_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      flash_cnt_q, flash_cnt_d;
  logic                  flash_on_q, flash_on_d;
  logic [NUM_WAYS-1:0]   green_q, yellow_q, red_q;
  logic [NUM_WAYS-1:0]   green_d, yellow_d, red_d;

  logic [NUM_WAYS-1:0]   way_mask;
  logic                  other_demand;
  logic [WW-1:0]         next_way;
  logic                  found;
  int                    idx;

  // Next-state logic: phase sequencing, demand-driven way selection, flash timing.
  always_comb begin
    state_d     = state_q;
    way_d       = way_q;
    flash_cnt_d = flash_cnt_q;
    flash_on_d  = flash_on_q;
    way_mask    = '0;
    way_mask[way_q] = 1'b1;
    other_demand = |(car_sense & ~way_mask);

    // Cyclic search from way_q+1; fall back to plain round-robin when nobody waits.
    found    = 1'b0;
    idx      = 0;
    next_way = WW'((int'(way_q) + 1) % NUM_WAYS);
    for (int k = 1; k <= NUM_WAYS; k++) begin
      idx = (int'(way_q) + k) % NUM_WAYS;
      if (!found && car_sense[idx]) begin
        found    = 1'b1;
        next_way = WW'(idx);
      end
    end

    case (state_q)
      ST_GREEN: begin
        if (cnt_q >= G_LAST && other_demand) state_d = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (cnt_q == Y_LAST) state_d = ST_ALL_RED;
      end
      ST_ALL_RED: begin
        if (cnt_q == AR_LAST) begin
          if (night_mode) begin
            state_d     = ST_FLASH;
            way_d       = LAST_WAY;  // so the search restarts at way 0 afterwards
            flash_on_d  = 1'b1;
            flash_cnt_d = '0;
          end else begin
            state_d = ST_GREEN;
            way_d   = next_way;
          end
        end
      end
      ST_FLASH: begin
        if (!night_mode) begin
          state_d = ST_ALL_RED;
        end else if (flash_cnt_q == F_LAST) begin
          flash_cnt_d = '0;
          flash_on_d  = ~flash_on_q;
        end else begin
          flash_cnt_d = flash_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_ALL_RED;
    endcase

    // Phase counter restarts on any state change and saturates during long greens.
    if (state_d != state_q)  cnt_d = '0;
    else if (&cnt_q)         cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CNT_W'(1);
  end

  // Lamp decode from next-state values so the lamp registers line up with the state.
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_lamp
    assign green_d[gi]  = (state_d == ST_GREEN) && (way_d == WW'(gi));
    assign yellow_d[gi] = ((state_d == ST_YELLOW) && (way_d == WW'(gi))) ||
                          ((state_d == ST_FLASH) && flash_on_d);
    assign red_d[gi]    = (state_d == ST_GREEN || state_d == ST_YELLOW) ?
                          (way_d != WW'(gi)) : (state_d == ST_ALL_RED);
  end

  // State, counters and lamp registers with synchronous reset to all-red.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ALL_RED;
      way_q       <= LAST_WAY;
      cnt_q       <= '0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b0;
      green_q     <= '0;
      yellow_q    <= '0;
      red_q       <= '1;
    end else begin
      state_q     <= state_d;
      way_q       <= way_d;
      cnt_q       <= cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      green_q     <= green_d;
      yellow_q    <= yellow_d;
      red_q       <= red_d;
    end
  end

  assign green      = green_q;
  assign yellow     = yellow_q;
  assign red        = red_q;
  assign active_way = way_q;
  assign phase_cnt  = cnt_q;

endmodule

// File: tb/tb_traffic_light_controller_nway.sv
// Directed bench for traffic_light_controller_nway (4 ways, green 6, yellow 3,
// all-red 2, flash 4) with a per-cycle invariant monitor.
module tb_traffic_light_controller_nway;

  logic       clk;
  logic       reset;
  logic [3:0] car_sense;
  logic       night_mode;
  logic [3:0] green, yellow, red;
  logic [1:0] active_way;
  logic [7:0] phase_cnt;

  int checks   = 0;
  int failures = 0;

  traffic_light_controller_nway #(
    .NUM_WAYS(4), .GREEN_CYCLES(6), .YELLOW_CYCLES(3),
    .ALLRED_CYCLES(2), .FLASH_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .car_sense(car_sense), .night_mode(night_mode),
    .green(green), .yellow(yellow), .red(red),
    .active_way(active_way), .phase_cnt(phase_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_state(input string tag, input logic [3:0] g, input logic [3:0] y,
                              input logic [3:0] r, input int aw, input int pc);
    chk({tag, ".green"},  32'(green),      32'(g));
    chk({tag, ".yellow"}, 32'(yellow),     32'(y));
    chk({tag, ".red"},    32'(red),        32'(r));
    chk({tag, ".way"},    32'(active_way), 32'(aw));
    chk({tag, ".cnt"},    32'(phase_cnt),  32'(pc));
    $display("t=%0t %s g=%b y=%b r=%b way=%0d cnt=%0d", $time, tag, green, yellow, red,
             active_way, phase_cnt);
  endtask

  // Invariant monitor: one lamp per approach, at most one non-red approach,
  // and every green-to-green handover goes through 3 yellow + 2 all-red cycles.
  logic [3:0] prev_green = '0;
  bit         seen_green = 1'b0;
  int         yel_run    = 0;
  int         red_run    = 0;
  always @(negedge clk) begin
    if (reset) begin
      seen_green = 1'b0; prev_green = '0; yel_run = 0; red_run = 0;
    end else if (red == 4'b0000 && green == 4'b0000) begin
      seen_green = 1'b0; prev_green = '0; yel_run = 0; red_run = 0;
    end else begin
      for (int i = 0; i < 4; i++)
        chk("inv.one_lamp", 32'(int'(green[i]) + int'(yellow[i]) + int'(red[i])), 32'd1);
      chk("inv.one_open", 32'($countones(~red) <= 1), 32'd1);
      if (green != 4'b0000) begin
        if (prev_green != 4'b0000)
          chk("inv.green_hold", 32'(green), 32'(prev_green));
        else if (seen_green) begin
          chk("inv.yellow_len", 32'(yel_run), 32'd3);
          chk("inv.allred_len", 32'(red_run), 32'd2);
        end
        seen_green = 1'b1; yel_run = 0; red_run = 0;
      end else if (yellow != 4'b0000) begin
        yel_run++; red_run = 0;
      end else begin
        red_run++;
      end
      prev_green = green;
    end
  end

  initial begin
    logic [3:0] m;
    reset = 1'b1; car_sense = 4'b1111; night_mode = 1'b0;

    // 1: reset, then full round-robin with all approaches demanding
    step(2);
    expect_state("rst", 4'b0000, 4'b0000, 4'b1111, 3, 0);
    reset = 1'b0;
    step(1);
    expect_state("init_ar1", 4'b0000, 4'b0000, 4'b1111, 3, 1);
    for (int w = 0; w < 4; w++) begin
      m = 4'(1 << w);
      step(1); expect_state($sformatf("rr%0d_g0", w), m, 4'b0000, ~m, w, 0);
      step(5); expect_state($sformatf("rr%0d_g5", w), m, 4'b0000, ~m, w, 5);
      step(1); expect_state($sformatf("rr%0d_y0", w), 4'b0000, m, ~m, w, 0);
      step(2); expect_state($sformatf("rr%0d_y2", w), 4'b0000, m, ~m, w, 2);
      step(1); expect_state($sformatf("rr%0d_ar0", w), 4'b0000, 4'b0000, 4'b1111, w, 0);
      step(1); expect_state($sformatf("rr%0d_ar1", w), 4'b0000, 4'b0000, 4'b1111, w, 1);
    end
    step(1);
    expect_state("rr_wrap_g0", 4'b0001, 4'b0000, 4'b1110, 0, 0);

    // 2: only ways 0 and 3 demand -> ways 1,2 skipped
    car_sense = 4'b1001;
    step(5); expect_state("skip_g5", 4'b0001, 4'b0000, 4'b1110, 0, 5);
    step(1); expect_state("skip_y0", 4'b0000, 4'b0001, 4'b1110, 0, 0);
    step(4); expect_state("skip_ar1", 4'b0000, 4'b0000, 4'b1111, 0, 1);
    step(1); expect_state("skip_g3", 4'b1000, 4'b0000, 4'b0111, 3, 0);

    // 3: green extension on way 0 until way 2 demands at phase_cnt=10
    car_sense = 4'b0001;
    step(6); expect_state("ext_y3", 4'b0000, 4'b1000, 4'b0111, 3, 0);
    step(5); expect_state("ext_g0", 4'b0001, 4'b0000, 4'b1110, 0, 0);
    step(9); expect_state("ext_g9", 4'b0001, 4'b0000, 4'b1110, 0, 9);
    step(1); expect_state("ext_g10", 4'b0001, 4'b0000, 4'b1110, 0, 10);
    car_sense = 4'b0101;
    step(1); expect_state("ext_y0", 4'b0000, 4'b0001, 4'b1110, 0, 0);
    step(2); expect_state("ext_y2", 4'b0000, 4'b0001, 4'b1110, 0, 2);
    step(1); expect_state("ext_ar0", 4'b0000, 4'b0000, 4'b1111, 0, 0);
    step(1); expect_state("ext_ar1", 4'b0000, 4'b0000, 4'b1111, 0, 1);
    step(1); expect_state("ext_g2", 4'b0100, 4'b0000, 4'b1011, 2, 0);

    // 4: night mode requested during way 1 green
    car_sense = 4'b0010;
    step(6); expect_state("nm_y2", 4'b0000, 4'b0100, 4'b1011, 2, 0);
    step(5); expect_state("nm_g1", 4'b0010, 4'b0000, 4'b1101, 1, 0);
    night_mode = 1'b1; car_sense = 4'b1111;
    step(5); expect_state("nm_g5", 4'b0010, 4'b0000, 4'b1101, 1, 5);
    step(1); expect_state("nm_y0", 4'b0000, 4'b0010, 4'b1101, 1, 0);
    step(3); expect_state("nm_ar0", 4'b0000, 4'b0000, 4'b1111, 1, 0);
    step(1); expect_state("nm_ar1", 4'b0000, 4'b0000, 4'b1111, 1, 1);
    step(1); expect_state("fl_on0", 4'b0000, 4'b1111, 4'b0000, 3, 0);
    step(3); expect_state("fl_on3", 4'b0000, 4'b1111, 4'b0000, 3, 3);
    step(1); expect_state("fl_off0", 4'b0000, 4'b0000, 4'b0000, 3, 4);
    step(3); expect_state("fl_off3", 4'b0000, 4'b0000, 4'b0000, 3, 7);
    step(1); expect_state("fl_on_again", 4'b0000, 4'b1111, 4'b0000, 3, 8);
    night_mode = 1'b0;
    step(1); expect_state("day_ar0", 4'b0000, 4'b0000, 4'b1111, 3, 0);
    step(1); expect_state("day_ar1", 4'b0000, 4'b0000, 4'b1111, 3, 1);
    step(1); expect_state("day_g0", 4'b0001, 4'b0000, 4'b1110, 0, 0);

    // 5: reset in the middle of yellow on way 2
    step(22); expect_state("mr_g2", 4'b0100, 4'b0000, 4'b1011, 2, 0);
    step(6);  expect_state("mr_y0", 4'b0000, 4'b0100, 4'b1011, 2, 0);
    step(1);  expect_state("mr_y1", 4'b0000, 4'b0100, 4'b1011, 2, 1);
    reset = 1'b1;
    step(1);  expect_state("mr_rst", 4'b0000, 4'b0000, 4'b1111, 3, 0);
    reset = 1'b0;
    step(1);  expect_state("mr_ar1", 4'b0000, 4'b0000, 4'b1111, 3, 1);
    step(1);  expect_state("mr_g0", 4'b0001, 4'b0000, 4'b1110, 0, 0);

    // Long extension: phase_cnt saturates at all-ones, then demand ends it
    car_sense = 4'b0001;
    step(300); expect_state("sat_g", 4'b0001, 4'b0000, 4'b1110, 0, 255);
    car_sense = 4'b0011;
    step(1);   expect_state("sat_y0", 4'b0000, 4'b0001, 4'b1110, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
